// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and byte-lane helpers for the unified-RAM arbiter.
// The RAM behind the arbiter is one byte wide; fetches and loads/stores are split into byte accesses.
package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_IF_RD  = 2'd1;
  localparam logic [1:0] ARB_MEM_RD = 2'd2;
  localparam logic [1:0] ARB_MEM_WR = 2'd3;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd3;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Index of the last byte of a transfer; the illegal code 2 behaves as a word.
  function automatic logic [1:0] len_last(input logic [1:0] len);
    logic [1:0] last;
    case (len)
      LEN_BYTE: last = 2'd0;
      LEN_HALF: last = 2'd1;
      LEN_WORD: last = 2'd3;
      default:  last = 2'd3;
    endcase
    return last;
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and load/store,
// serialising little-endian 1/2/4-byte transfers; MEM wins ties, IF fetches abort on flush.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_interception,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_len,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic                  stall_req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);

  logic [1:0]            state_r,     state_nx;
  logic [2:0]            step_r,      step_nx;
  logic [1:0]            last_r,      last_nx;
  logic [31:0]           wdata_r,     wdata_nx;
  logic [31:0]           asm_r,       asm_nx;
  logic [ADDR_WIDTH-1:0] ram_addr_r,  ram_addr_nx;
  logic                  ram_we_r,    ram_we_nx;
  logic [7:0]            ram_dout_r,  ram_dout_nx;
  logic                  if_done_r,   if_done_nx;
  logic                  mem_done_r,  mem_done_nx;
  logic [31:0]           if_inst_r,   if_inst_nx;
  logic [31:0]           mem_rdata_r, mem_rdata_nx;

  // step_r counts edges since the grant edge, so k_s is the index of the edge being computed.
  logic [2:0] k_s;
  logic [2:0] last_ext_s;
  logic [1:0] cap_idx_s;

  // Next-state and datapath computation for the arbiter FSM.
  always_comb begin
    state_nx     = state_r;
    step_nx      = step_r;
    last_nx      = last_r;
    wdata_nx     = wdata_r;
    asm_nx       = asm_r;
    ram_addr_nx  = ram_addr_r;
    ram_we_nx    = 1'b0;
    ram_dout_nx  = ram_dout_r;
    if_done_nx   = 1'b0;
    mem_done_nx  = 1'b0;
    if_inst_nx   = if_inst_r;
    mem_rdata_nx = mem_rdata_r;
    k_s          = step_r + 3'd1;
    last_ext_s   = {1'b0, last_r};
    cap_idx_s    = k_s[1:0] - 2'd2;

    case (state_r)
      ARB_IDLE: begin
        // The cycle a done pulse is visible is a turnaround: the requester retires first.
        if (if_done_r || mem_done_r) begin
          state_nx = ARB_IDLE;
        end else if (mem_req) begin
          last_nx     = len_last(mem_len);
          ram_addr_nx = mem_addr;
          step_nx     = 3'd0;
          asm_nx      = ZERO_WORD;
          if (mem_we) begin
            state_nx    = ARB_MEM_WR;
            wdata_nx    = mem_wdata;
            ram_we_nx   = 1'b1;
            ram_dout_nx = mem_wdata[7:0];
          end else begin
            state_nx = ARB_MEM_RD;
          end
        end else if (if_req && !branch_interception) begin
          state_nx    = ARB_IF_RD;
          last_nx     = LEN_WORD;
          ram_addr_nx = if_addr;
          step_nx     = 3'd0;
          asm_nx      = ZERO_WORD;
        end else begin
          state_nx = ARB_IDLE;
        end
      end

      ARB_IF_RD, ARB_MEM_RD: begin
        if ((state_r == ARB_IF_RD) && branch_interception) begin
          state_nx = ARB_IDLE;
        end else begin
          step_nx = k_s;
          if (k_s <= last_ext_s) begin
            ram_addr_nx = ram_addr_r + ADDR_ONE;
          end else begin
            ram_addr_nx = ram_addr_r;
          end
          // The RAM answers one cycle after the address, so captures trail launches by two edges.
          if (k_s >= 3'd2) begin
            asm_nx = put_byte(asm_r, cap_idx_s, ram_din);
          end else begin
            asm_nx = asm_r;
          end
          if (k_s == (last_ext_s + 3'd2)) begin
            state_nx = ARB_IDLE;
            if (state_r == ARB_IF_RD) begin
              if_done_nx = 1'b1;
              if_inst_nx = asm_nx;
            end else begin
              mem_done_nx  = 1'b1;
              mem_rdata_nx = asm_nx;
            end
          end else begin
            state_nx = state_r;
          end
        end
      end

      ARB_MEM_WR: begin
        if (k_s == (last_ext_s + 3'd1)) begin
          state_nx    = ARB_IDLE;
          mem_done_nx = 1'b1;
        end else begin
          step_nx     = k_s;
          ram_addr_nx = ram_addr_r + ADDR_ONE;
          ram_we_nx   = 1'b1;
          ram_dout_nx = word_byte(wdata_r, k_s[1:0]);
        end
      end

      default: begin
        state_nx = ARB_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ARB_IDLE;
      step_r      <= 3'd0;
      last_r      <= 2'd0;
      wdata_r     <= ZERO_WORD;
      asm_r       <= ZERO_WORD;
      ram_addr_r  <= ADDR_ZERO;
      ram_we_r    <= 1'b0;
      ram_dout_r  <= 8'h00;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      if_inst_r   <= ZERO_WORD;
      mem_rdata_r <= ZERO_WORD;
    end else begin
      state_r     <= state_nx;
      step_r      <= step_nx;
      last_r      <= last_nx;
      wdata_r     <= wdata_nx;
      asm_r       <= asm_nx;
      ram_addr_r  <= ram_addr_nx;
      ram_we_r    <= ram_we_nx;
      ram_dout_r  <= ram_dout_nx;
      if_done_r   <= if_done_nx;
      mem_done_r  <= mem_done_nx;
      if_inst_r   <= if_inst_nx;
      mem_rdata_r <= mem_rdata_nx;
    end
  end

  assign if_done   = if_done_r;
  assign if_inst   = if_inst_r;
  assign mem_done  = mem_done_r;
  assign mem_rdata = mem_rdata_r;
  assign ram_addr  = ram_addr_r;
  assign ram_we    = ram_we_r;
  assign ram_dout  = ram_dout_r;
  assign stall_req = mem_req && !mem_done_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus hand-written
// sequences for contention, flush and reset; a synchronous byte RAM model sits on the port.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_interception;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        stall_req;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .branch_interception(branch_interception),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stall_req(stall_req), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // Byte RAM: data for the address seen at an edge appears after that edge.
  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = 16'h0;
  logic [7:0]  pl_data = 8'h0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr[15:0]] <= ram_dout;
    ram_din <= mem[ram_addr[15:0]];
  end

  typedef struct {
    string       name;
    logic        is_if;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Issue one transaction from an idle DUT and check every cycle until one idle cycle after done.
  task automatic run_vec(input vec_t v);
    int n;
    int lat;
    logic [31:0] sh;
    n   = v.is_if ? 4 : ((v.len == 2'd2) ? 4 : int'(v.len) + 1);
    lat = (v.is_if || !v.we) ? n + 1 : n;
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      mem_req = 1'b1; mem_we = v.we; mem_len = v.len; mem_addr = v.addr; mem_wdata = v.wdata;
    end
    for (int c = 0; c <= lat; c++) begin
      tick();
      if (v.is_if) begin
        chk($sformatf("%s c%0d if_done", v.name, c), 32'(if_done), 32'(c == lat));
        chk($sformatf("%s c%0d mem_done", v.name, c), 32'(mem_done), 32'd0);
      end else begin
        chk($sformatf("%s c%0d mem_done", v.name, c), 32'(mem_done), 32'(c == lat));
        chk($sformatf("%s c%0d if_done", v.name, c), 32'(if_done), 32'd0);
      end
      chk($sformatf("%s c%0d stall", v.name, c), 32'(stall_req), 32'(!v.is_if && c < lat));
      if (v.we && !v.is_if) begin
        chk($sformatf("%s c%0d ram_we", v.name, c), 32'(ram_we), 32'(c < n));
        if (c < n) begin
          sh = v.wdata >> (8 * c);
          chk($sformatf("%s c%0d ram_addr", v.name, c), ram_addr, v.addr + 32'(c));
          chk($sformatf("%s c%0d ram_dout", v.name, c), 32'(ram_dout), 32'(sh[7:0]));
        end
      end else begin
        chk($sformatf("%s c%0d ram_we", v.name, c), 32'(ram_we), 32'd0);
        if (c < n) chk($sformatf("%s c%0d ram_addr", v.name, c), ram_addr, v.addr + 32'(c));
      end
      if (c == lat) begin
        if (v.is_if) begin
          chk($sformatf("%s if_inst", v.name), if_inst, v.exp_rdata);
          if_req = 1'b0;
        end else begin
          if (!v.we) chk($sformatf("%s mem_rdata", v.name), mem_rdata, v.exp_rdata);
          mem_req = 1'b0;
        end
      end
    end
    tick();
    chk($sformatf("%s idle dones", v.name), 32'({if_done, mem_done}), 32'd0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; branch_interception = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;

    vt[0] = '{"if_word",     1'b1, 1'b0, 2'd3, 32'h0000_0100, 32'h0,         32'h0010_0513};
    vt[1] = '{"ld_byte",     1'b0, 1'b0, 2'd0, 32'h0000_2000, 32'h0,         32'h0000_00FF};
    vt[2] = '{"ld_half",     1'b0, 1'b0, 2'd1, 32'h0000_3001, 32'h0,         32'h0000_3322};
    vt[3] = '{"ld_word",     1'b0, 1'b0, 2'd3, 32'h0000_3000, 32'h0,         32'h4433_2211};
    vt[4] = '{"ld_len2",     1'b0, 1'b0, 2'd2, 32'h0000_3000, 32'h0,         32'h4433_2211};
    vt[5] = '{"st_wrap",     1'b0, 1'b1, 2'd3, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'h0};
    vt[6] = '{"ld_wrap",     1'b0, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0,         32'hDEAD_BEEF};
    vt[7] = '{"st_byte",     1'b0, 1'b1, 2'd0, 32'h0000_3002, 32'h1234_56A5, 32'h0};
    vt[8] = '{"ld_after_sb", 1'b0, 1'b0, 2'd3, 32'h0000_3000, 32'h0,         32'h44A5_2211};
    vt[9] = '{"if_word2",    1'b1, 1'b0, 2'd3, 32'h0000_0200, 32'h0,         32'h0000_0093};

    @(negedge clk);
    preload(16'h0100, 8'h13); preload(16'h0101, 8'h05);
    preload(16'h0102, 8'h10); preload(16'h0103, 8'h00);
    preload(16'h0200, 8'h93); preload(16'h0201, 8'h00);
    preload(16'h0202, 8'h00); preload(16'h0203, 8'h00);
    preload(16'h2000, 8'hFF);
    preload(16'h3000, 8'h11); preload(16'h3001, 8'h22);
    preload(16'h3002, 8'h33); preload(16'h3003, 8'h44);

    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst ram_addr", ram_addr, 32'd0);
    chk("rst ram_dout", 32'(ram_dout), 32'd0);
    chk("rst dones", 32'({if_done, mem_done}), 32'd0);
    chk("rst if_inst", if_inst, 32'd0);
    chk("rst mem_rdata", mem_rdata, 32'd0);
    chk("rst stall", 32'(stall_req), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Contention: byte load and fetch raised together; load first, fetch after turnaround.
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h0000_2000;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    for (int c = 0; c <= 11; c++) begin
      tick();
      chk($sformatf("both c%0d mem_done", c), 32'(mem_done), 32'(c == 2));
      chk($sformatf("both c%0d if_done", c), 32'(if_done), 32'(c == 9));
      chk($sformatf("both c%0d stall", c), 32'(stall_req), 32'(c < 2));
      if (c == 2) begin
        chk("both mem_rdata", mem_rdata, 32'h0000_00FF);
        mem_req = 1'b0;
      end
      if (c == 4) chk("both if grant addr", ram_addr, 32'h0000_0100);
      if (c == 9) begin
        chk("both if_inst", if_inst, 32'h0010_0513);
        if_req = 1'b0;
      end
    end

    // Flush in cycle 2 of a fetch, then a new fetch at 0x200.
    if_req = 1'b1; if_addr = 32'h0000_0100;
    for (int c = 0; c <= 10; c++) begin
      tick();
      chk($sformatf("flush c%0d if_done", c), 32'(if_done), 32'(c == 9));
      if (c == 2) branch_interception = 1'b1;
      if (c == 3) begin
        branch_interception = 1'b0;
        if_addr = 32'h0000_0200;
      end
      if (c == 4) chk("flush regrant addr", ram_addr, 32'h0000_0200);
      if (c == 9) begin
        chk("flush if_inst", if_inst, 32'h0000_0093);
        if_req = 1'b0;
      end
    end

    // Flush held high throughout a half store: the store completes untouched.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd1; mem_addr = 32'h0000_0300;
    mem_wdata = 32'h0000_BEEF; branch_interception = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      tick();
      chk($sformatf("st_flush c%0d ram_we", c), 32'(ram_we), 32'(c < 2));
      chk($sformatf("st_flush c%0d mem_done", c), 32'(mem_done), 32'(c == 2));
      if (c == 0) chk("st_flush b0", {ram_addr[23:0], ram_dout}, 32'h0003_00EF);
      if (c == 1) chk("st_flush b1", {ram_addr[23:0], ram_dout}, 32'h0003_01BE);
      if (c == 2) begin
        mem_req = 1'b0;
        branch_interception = 1'b0;
      end
    end
    v = '{"ld_st_flush", 1'b0, 1'b0, 2'd1, 32'h0000_0300, 32'h0, 32'h0000_BEEF};
    run_vec(v);

    // Reset during a word store after three bytes: last byte never written, no done pulse.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h0000_3000;
    mem_wdata = 32'h5566_7788;
    for (int c = 0; c <= 2; c++) begin
      tick();
      chk($sformatf("st_rst c%0d ram_we", c), 32'(ram_we), 32'd1);
      chk($sformatf("st_rst c%0d mem_done", c), 32'(mem_done), 32'd0);
    end
    rst = 1'b1; mem_req = 1'b0;
    tick();
    chk("st_rst ram_we", 32'(ram_we), 32'd0);
    chk("st_rst ram_addr", ram_addr, 32'd0);
    chk("st_rst ram_dout", 32'(ram_dout), 32'd0);
    chk("st_rst dones", 32'({if_done, mem_done}), 32'd0);
    chk("st_rst if_inst", if_inst, 32'd0);
    chk("st_rst mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("st_rst post mem_done", 32'(mem_done), 32'd0);
    v = '{"ld_after_rst", 1'b0, 1'b0, 2'd3, 32'h0000_3000, 32'h0, 32'h4466_7788};
    run_vec(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
